// File: rtl/flash_mp_check.sv
// Flash memory-protection checker.
// Snapshots a request together with the region configuration, scans one region per cycle
// (lowest index wins) and returns the permission verdict over a valid/ready response.
module flash_mp_check #(
  parameter int unsigned MpRegions = 8  // configurable regions; index MpRegions is the default
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             req_valid_i,
  output logic                             req_ready_o,
  input  logic [8:0]                       req_page_i,
  input  logic [1:0]                       req_op_i,
  input  logic [(MpRegions+1)*19-1:0]      region_cfgs_i,
  input  logic [MpRegions:0]               region_en_i,
  input  logic [MpRegions:0]               rd_en_i,
  input  logic [MpRegions:0]               prog_en_i,
  input  logic [MpRegions:0]               erase_en_i,
  output logic                             rsp_valid_o,
  input  logic                             rsp_ready_i,
  output logic                             rsp_allow_o,
  output logic                             rsp_err_o,
  output logic [3:0]                       rsp_region_o
);

  localparam int unsigned NumRegions = MpRegions + 1;
  localparam int unsigned CfgW       = 19;
  localparam logic [3:0]  LastIdx    = 4'(MpRegions - 1);
  localparam logic [3:0]  DefIdx     = 4'(MpRegions);

  typedef enum logic [1:0] {StIdle, StScan, StResp} state_e;

  state_e                      r_state;
  logic [3:0]                  r_idx;
  logic [8:0]                  r_page;
  logic [1:0]                  r_op;
  logic [MpRegions*CfgW-1:0]   r_cfgs;       // default region has no address range
  logic [MpRegions-1:0]        r_region_en;  // default region enable is ignored
  logic [MpRegions:0]          r_rd_en;
  logic [MpRegions:0]          r_prog_en;
  logic [MpRegions:0]          r_erase_en;
  logic                        r_req_ready;
  logic                        r_rsp_valid;
  logic                        r_rsp_allow;
  logic                        r_rsp_err;
  logic [3:0]                  r_rsp_region;

  logic [CfgW-1:0]             w_cfg;
  logic                        w_en;
  logic [8:0]                  w_base;
  logic [9:0]                  w_size;
  logic [10:0]                 w_limit;
  logic                        w_hit;
  logic [3:0]                  w_sel;
  logic                        w_rd;
  logic                        w_prog;
  logic                        w_erase;
  logic                        w_allow;
  logic                        w_err;
  logic                        w_unused;

  // The default region's enable and address range never influence the result.
  assign w_unused = ^{region_en_i[MpRegions], region_cfgs_i[NumRegions*CfgW-1 -: CfgW]};

  // Evaluate the region under the scan index and decode the permission of the selected region.
  always_comb begin
    w_cfg = '0;
    w_en  = 1'b0;
    for (int unsigned i = 0; i < MpRegions; i++) begin
      if (r_idx == 4'(i)) begin
        w_cfg = r_cfgs[i*CfgW +: CfgW];
        w_en  = r_region_en[i];
      end
    end
    w_base  = w_cfg[18:10];
    w_size  = w_cfg[9:0];
    // 11-bit limit so ranges running past the top page never wrap back to page 0.
    w_limit = {2'b00, w_base} + {1'b0, w_size};
    w_hit   = w_en && (w_size != '0) && (r_page >= w_base) && ({2'b00, r_page} < w_limit);
    w_sel   = w_hit ? r_idx : DefIdx;

    w_rd    = 1'b0;
    w_prog  = 1'b0;
    w_erase = 1'b0;
    for (int unsigned i = 0; i < NumRegions; i++) begin
      if (w_sel == 4'(i)) begin
        w_rd    = r_rd_en[i];
        w_prog  = r_prog_en[i];
        w_erase = r_erase_en[i];
      end
    end

    w_allow = 1'b0;
    w_err   = 1'b0;
    case (r_op)
      2'b00:   w_allow = w_rd;
      2'b01:   w_allow = w_prog;
      2'b10:   w_allow = w_erase;
      default: w_err   = 1'b1;
    endcase
  end

  // Request/scan/response sequencing with registered handshake and result outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state      <= StIdle;
      r_idx        <= '0;
      r_page       <= '0;
      r_op         <= '0;
      r_cfgs       <= '0;
      r_region_en  <= '0;
      r_rd_en      <= '0;
      r_prog_en    <= '0;
      r_erase_en   <= '0;
      r_req_ready  <= 1'b1;
      r_rsp_valid  <= 1'b0;
      r_rsp_allow  <= 1'b0;
      r_rsp_err    <= 1'b0;
      r_rsp_region <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (req_valid_i) begin
            r_page      <= req_page_i;
            r_op        <= req_op_i;
            r_cfgs      <= region_cfgs_i[MpRegions*CfgW-1:0];
            r_region_en <= region_en_i[MpRegions-1:0];
            r_rd_en     <= rd_en_i;
            r_prog_en   <= prog_en_i;
            r_erase_en  <= erase_en_i;
            r_idx       <= '0;
            r_req_ready <= 1'b0;
            r_state     <= StScan;
          end
        end
        StScan: begin
          if (w_hit || (r_idx == LastIdx)) begin
            r_rsp_valid  <= 1'b1;
            r_rsp_allow  <= w_allow;
            r_rsp_err    <= w_err;
            r_rsp_region <= w_sel;
            r_state      <= StResp;
          end else begin
            r_idx <= r_idx + 4'd1;
          end
        end
        StResp: begin
          if (rsp_ready_i) begin
            r_rsp_valid  <= 1'b0;
            r_rsp_allow  <= 1'b0;
            r_rsp_err    <= 1'b0;
            r_rsp_region <= '0;
            r_idx        <= '0;
            r_req_ready  <= 1'b1;
            r_state      <= StIdle;
          end
        end
        default: begin
          r_state     <= StIdle;
          r_req_ready <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready_o  = r_req_ready;
  assign rsp_valid_o  = r_rsp_valid;
  assign rsp_allow_o  = r_rsp_allow;
  assign rsp_err_o    = r_rsp_err;
  assign rsp_region_o = r_rsp_region;

endmodule

// File: tb/tb_flash_mp_check.sv
// Directed, table-driven bench for flash_mp_check with hand-computed expectations.
module tb_flash_mp_check;

  localparam int unsigned MpRegions = 8;
  localparam int unsigned NR        = MpRegions + 1;

  logic              clk;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic [8:0]        req_page;
  logic [1:0]        req_op;
  logic [NR*19-1:0]  cfgs;
  logic [NR-1:0]     region_en;
  logic [NR-1:0]     rd_en;
  logic [NR-1:0]     prog_en;
  logic [NR-1:0]     erase_en;
  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_allow;
  logic              rsp_err;
  logic [3:0]        rsp_region;

  int n_checks;
  int n_errors;

  flash_mp_check #(.MpRegions(MpRegions)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_page_i   (req_page),
    .req_op_i     (req_op),
    .region_cfgs_i(cfgs),
    .region_en_i  (region_en),
    .rd_en_i      (rd_en),
    .prog_en_i    (prog_en),
    .erase_en_i   (erase_en),
    .rsp_valid_o  (rsp_valid),
    .rsp_ready_i  (rsp_ready),
    .rsp_allow_o  (rsp_allow),
    .rsp_err_o    (rsp_err),
    .rsp_region_o (rsp_region)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [8:0] page;
    logic [1:0] op;
    int         region;
    int         allow;
    int         err;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic set_region(input int idx, input logic [8:0] base, input logic [9:0] size,
                            input logic en, input logic rd, input logic pr, input logic er);
    cfgs[idx*19 +: 19] = {base, size};
    region_en[idx]     = en;
    rd_en[idx]         = rd;
    prog_en[idx]       = pr;
    erase_en[idx]      = er;
  endtask

  task automatic base_config();
    set_region(0, 9'h010, 10'h020, 1'b1, 1'b1, 1'b0, 1'b0);
    set_region(1, 9'h080, 10'h010, 1'b1, 1'b1, 1'b1, 1'b1);
    set_region(2, 9'h040, 10'h008, 1'b1, 1'b1, 1'b0, 1'b1);
    set_region(3, 9'h1F0, 10'h3FF, 1'b0, 1'b1, 1'b1, 1'b0);
    set_region(4, 9'h100, 10'h000, 1'b1, 1'b1, 1'b1, 1'b1);
    set_region(5, 9'h03C, 10'h010, 1'b1, 1'b0, 1'b1, 1'b0);
    set_region(6, 9'h000, 10'h200, 1'b0, 1'b1, 1'b1, 1'b1);
    set_region(7, 9'h0A0, 10'h020, 1'b1, 1'b0, 1'b1, 1'b1);
    set_region(8, 9'h000, 10'h000, 1'b0, 1'b1, 1'b0, 1'b1);
  endtask

  // Drive a request and consume the accept edge; returns 1 cycle after it.
  task automatic start_req(input logic [8:0] page, input logic [1:0] op);
    req_page  = page;
    req_op    = op;
    req_valid = 1'b1;
    chk("req_ready_idle", int'(req_ready), 1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk("req_ready_busy", int'(req_ready), 0);
  endtask

  // n = number of rising edges after the accept edge when rsp_valid was first seen.
  task automatic wait_rsp(input int start, output int n);
    int zero_bad;
    n = start;
    zero_bad = 0;
    while (!rsp_valid && n < 40) begin
      if (rsp_allow || rsp_err || rsp_region != 4'd0) zero_bad = 1;
      @(posedge clk);
      #1;
      n++;
    end
    chk("fields_zero_while_invalid", zero_bad, 0);
    if (!rsp_valid) chk("rsp_timeout", 0, 1);
  endtask

  // Accept in cycle T, hit at k visible in T+2+k, i.e. k+1 edges after the accept edge.
  task automatic check_rsp(input string name, input int n, input int region, input int allow,
                           input int err);
    int lat;
    lat = (region == int'(MpRegions)) ? int'(MpRegions) : region + 1;
    chk({name, "_latency"}, n, lat);
    chk({name, "_valid"}, int'(rsp_valid), 1);
    chk({name, "_region"}, int'(rsp_region), region);
    chk({name, "_allow"}, int'(rsp_allow), allow);
    chk({name, "_err"}, int'(rsp_err), err);
  endtask

  task automatic finish_rsp();
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    chk("done_valid_low", int'(rsp_valid), 0);
    chk("done_req_ready", int'(req_ready), 1);
    chk("done_fields_zero", int'({rsp_allow, rsp_err, rsp_region}), 0);
  endtask

  task automatic run_vec(input vec_t v);
    int n;
    start_req(v.page, v.op);
    wait_rsp(0, n);
    check_rsp(v.name, n, v.region, v.allow, v.err);
    finish_rsp();
  endtask

  initial begin
    int n;
    int bad;
    vec_t v;
    n_checks  = 0;
    n_errors  = 0;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_page  = '0;
    req_op    = '0;
    rsp_ready = 1'b0;
    cfgs      = '0;
    region_en = '0;
    rd_en     = '0;
    prog_en   = '0;
    erase_en  = '0;
    base_config();

    //            name          page    op     region allow err
    vecs[0]  = '{"r0_read",     9'h015, 2'b00, 0, 1, 0};
    vecs[1]  = '{"r2_prio",     9'h040, 2'b01, 2, 0, 0};
    vecs[2]  = '{"r2_end_excl", 9'h048, 2'b01, 5, 1, 0};
    vecs[3]  = '{"dflt_erase",  9'h1FF, 2'b10, 8, 1, 0};
    vecs[4]  = '{"r1_illegal",  9'h081, 2'b11, 1, 0, 1};
    vecs[5]  = '{"below_base",  9'h00F, 2'b00, 8, 1, 0};
    vecs[6]  = '{"r0_last",     9'h02F, 2'b00, 0, 1, 0};
    vecs[7]  = '{"dflt_prog",   9'h030, 2'b01, 8, 0, 0};
    vecs[8]  = '{"r7_last_pg",  9'h0BF, 2'b10, 7, 1, 0};
    vecs[9]  = '{"size_zero",   9'h100, 2'b00, 8, 1, 0};
    vecs[10] = '{"r1_read",     9'h085, 2'b00, 1, 1, 0};
    vecs[11] = '{"r2_erase",    9'h043, 2'b10, 2, 1, 0};
    vecs[12] = '{"r7_no_rd",    9'h0A0, 2'b00, 7, 0, 0};
    vecs[13] = '{"r5_illegal",  9'h04B, 2'b11, 5, 0, 1};

    #1;
    chk("reset_valid", int'(rsp_valid), 0);
    chk("reset_fields", int'({rsp_allow, rsp_err, rsp_region}), 0);
    #21;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_reset_ready", int'(req_ready), 1);
    chk("post_reset_valid", int'(rsp_valid), 0);

    for (int i = 0; i < 14; i++) run_vec(vecs[i]);

    // Large region reaching past the top page covers page 0x1FF.
    set_region(3, 9'h1F0, 10'h3FF, 1'b1, 1'b1, 1'b1, 1'b0);
    v = '{"r3_nowrap_er", 9'h1FF, 2'b10, 3, 0, 0};
    run_vec(v);
    v = '{"r3_nowrap_rd", 9'h1FF, 2'b00, 3, 1, 0};
    run_vec(v);
    base_config();

    // Response held for 5 cycles while every input changes.
    start_req(9'h015, 2'b00);
    wait_rsp(0, n);
    check_rsp("hold_start", n, 0, 1, 0);
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      for (int r = 0; r < int'(NR); r++) cfgs[r*19 +: 19] = 19'($urandom);
      region_en = 9'($urandom);
      rd_en     = 9'($urandom) & 9'h1FE;
      prog_en   = 9'($urandom);
      erase_en  = 9'($urandom);
      req_valid = 1'b1;
      req_page  = 9'($urandom);
      req_op    = 2'($urandom);
      @(posedge clk);
      #1;
      if (!rsp_valid || rsp_region != 4'd0 || !rsp_allow || rsp_err || req_ready) bad++;
    end
    chk("hold_stable_cycles_bad", bad, 0);
    req_valid = 1'b0;
    base_config();
    finish_rsp();

    // Config, page and op change mid-scan; a stray rsp_ready during scan is ignored.
    start_req(9'h1FF, 2'b10);
    @(posedge clk);
    #1;
    region_en = '1;
    erase_en  = '0;
    req_page  = 9'h015;
    req_op    = 2'b00;
    req_valid = 1'b1;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    wait_rsp(2, n);
    check_rsp("snapshot", n, 8, 1, 0);
    base_config();
    finish_rsp();

    // Reset mid-scan aborts with no response.
    start_req(9'h0BF, 2'b10);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_scan_valid", int'(rsp_valid), 0);
    chk("abort_scan_fields", int'({rsp_allow, rsp_err, rsp_region}), 0);
    #3;
    rst_n = 1'b1;
    bad = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk);
      #1;
      if (rsp_valid) bad++;
    end
    chk("abort_no_response", bad, 0);
    chk("abort_ready", int'(req_ready), 1);
    v = '{"after_abort", 9'h015, 2'b00, 0, 1, 0};
    run_vec(v);

    // Reset while a response is pending.
    start_req(9'h085, 2'b00);
    wait_rsp(0, n);
    check_rsp("resp_abort_pre", n, 1, 1, 0);
    rst_n = 1'b0;
    #1;
    chk("abort_resp_valid", int'(rsp_valid), 0);
    chk("abort_resp_allow", int'(rsp_allow), 0);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_resp_ready", int'(req_ready), 1);
    chk("abort_resp_still_low", int'(rsp_valid), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/flash_mp_check.md
FLASH_MP_CHECK -- requirements
Module: flash_mp_check

Interface
REQ-001 Parameters SHALL be: MpRegions, default 8, number of configurable regions; region index MpRegions is the default region.
REQ-002 Port SHALL be: clk_i  input  1  single clock, all state rising-edge.
REQ-003 Port SHALL be: rst_ni  input  1  reset, asynchronous, active-low.
REQ-004 Port SHALL be: req_valid_i  input  1  request valid.
REQ-005 Port SHALL be: req_ready_o  output  1  request accepted when high with req_valid_i.
REQ-006 Port SHALL be: req_page_i  input  9  target page.
REQ-007 Port SHALL be: req_op_i  input  2  00 read, 01 program, 10 erase, 11 illegal.
REQ-008 Port SHALL be: region_cfgs_i  input  (MpRegions+1)*19  packed {base[8:0], size[9:0]} per region; index 0 in LSBs.
REQ-009 Ports SHALL be: region_en_i, rd_en_i, prog_en_i, erase_en_i  input  MpRegions+1 each  per-region enable and permissions.
REQ-010 Port SHALL be: rsp_valid_o  output  1  response valid.
REQ-011 Port SHALL be: rsp_ready_i  input  1  response consumed.
REQ-012 Ports SHALL be: rsp_allow_o 1, rsp_err_o 1, rsp_region_o 4  output  permission result, illegal-op flag, matched region index.

Function
REQ-013 FSM SHALL have states IDLE, SCAN, RESP; req_ready_o SHALL be 1 only in IDLE.
REQ-014 On accept (IDLE, req_valid_i=1) the block SHALL capture page, op, region_cfgs_i and all enable vectors, clear scan index to 0, enter SCAN.
REQ-015 Captured snapshot SHALL be used for the whole scan; input changes after accept SHALL NOT affect the result.
REQ-016 SCAN SHALL evaluate exactly one region per cycle, index 0 upward, lowest index having priority.
REQ-017 Region k SHALL hit iff region_en[k]=1, size!=0, page>=base, and page < base+size computed at 11 bits (no wrap; region reaching past page 511 covers to 511).
REQ-018 First hit at index k<MpRegions SHALL record k and enter RESP next cycle.
REQ-019 If index MpRegions-1 is evaluated without hit, the block SHALL select region MpRegions unconditionally (default, enable ignored) and enter RESP.
REQ-020 Latency: accept edge at cycle T, rsp_valid_o SHALL first be high in cycle T+2+k for hit at k, and T+1+MpRegions for default.
REQ-021 rsp_allow_o SHALL equal rd_en[k], prog_en[k] or erase_en[k] for op 00/01/10; for op 11 rsp_allow_o=0 and rsp_err_o=1; otherwise rsp_err_o=0.
REQ-022 In RESP rsp_valid_o SHALL be 1 with all rsp_* fields stable until rsp_ready_i=1; on that edge the block SHALL return to IDLE.
REQ-023 rsp_ready_i asserted outside RESP SHALL be ignored; req_valid_i outside IDLE SHALL NOT be accepted (no back-to-back; one request per latency+1 cycles minimum).
REQ-024 rsp_allow_o, rsp_err_o, rsp_region_o SHALL be 0 whenever rsp_valid_o=0.

Reset
REQ-025 rst_ni low SHALL asynchronously force IDLE, scan index 0, rsp_valid_o=0, rsp_allow_o=0, rsp_err_o=0, rsp_region_o=0; req_ready_o=1 after reset releases.
REQ-026 Reset asserted during SCAN or RESP SHALL abort the request with no response issued.

Verification
REQ-027 Region 0 {base=0x10,size=0x20,en,rd}, read page 0x15 -> rsp_valid at T+2, region=0, allow=1, err=0.
REQ-028 Regions 2 and 5 both cover page 0x40, region 2 prog_en=0, region 5 prog_en=1, program op -> region=2, allow=0 at T+4.
REQ-029 No enabled region covers page 0x1FF, default region erase_en=1, erase op -> region=8, allow=1 at T+9; region 3 {base=0x1F0,size=0x3FF} then hits page 0x1FF (no wrap).
REQ-030 op=11 on page hitting region 1 with all perms 1 -> region=1, allow=0, err=1.
REQ-031 Hold rsp_ready_i=0 for 5 cycles in RESP while changing all inputs -> outputs stable, req_ready_o=0; config changed mid-SCAN -> result from snapshot.
REQ-032 Assert rst_ni=0 mid-SCAN -> rsp_valid_o=0 immediately, next request processed correctly from index 0.
